// File: rtl/uart_tx_fifo.sv
// Host-side transmit FIFO feeding a UART TX control FSM with single-cycle launch pulses.
// Define UART_TX_FIFO_OVERFLOW_FLAG_EN to enable the sticky OVERFLOW flag for dropped pushes.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_EN,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [$clog2(DEPTH):0]  COUNT,
  input  logic                    TX_BUSY,
  output logic                    TX_DATA_VALID,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  input  logic                    OVF_CLR,
  output logic                    OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state, state_next;
  logic                    push, pop;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // A push is refused whenever the FIFO is full, even if a pop frees a slot on the same edge.
  assign push          = WR_EN && !FULL;
  assign TX_DATA_VALID = (state == LAUNCH);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY && !TX_BUSY) begin
          state_next = LAUNCH;
          pop        = 1'b1;
        end
      end
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: if (TX_BUSY)  state_next = WAIT_DONE;
      WAIT_DONE: if (!TX_BUSY) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = COUNT;
    case ({push, pop})
      2'b10:   count_next = COUNT + CNT_ONE;
      2'b01:   count_next = COUNT - CNT_ONE;
      default: count_next = COUNT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      COUNT     <= '0;
      EMPTY     <= 1'b1;
      FULL      <= 1'b0;
      TX_P_DATA <= '0;
    end else begin
      state <= state_next;
      COUNT <= count_next;
      EMPTY <= (count_next == '0);
      FULL  <= (count_next == CNT_FULL);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        TX_P_DATA <= mem[rd_ptr];
      end
    end
  end

  // Storage is left unreset; COUNT and the pointers define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      OVERFLOW <= 1'b0;
    else if (WR_EN && FULL)
      OVERFLOW <= 1'b1;
    else if (OVF_CLR)
      OVERFLOW <= 1'b0;
  end
`else
  logic ovf_clr_unused;
  assign ovf_clr_unused = OVF_CLR;
  assign OVERFLOW       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed pushes queue expected bytes, a monitor checks each launch.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy_force;
  logic       busy_model;
  logic       tx_busy;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       ovf_clr;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  logic [7:0] exp_q[$];

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  assign tx_busy = busy_force | busy_model;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .CLK          (clk),
    .RST          (rst),
    .WR_EN        (wr_en),
    .WR_DATA      (wr_data),
    .FULL         (full),
    .EMPTY        (empty),
    .COUNT        (count),
    .TX_BUSY      (tx_busy),
    .TX_DATA_VALID(tx_valid),
    .TX_P_DATA    (tx_data),
    .OVF_CLR      (ovf_clr),
    .OVERFLOW     (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (empty !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < limit), 32'd1);
    repeat (20) tick();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
    busy_force = 1'b0; busy_model = 1'b0;

    fork
      begin : monitor
        logic       prev_valid = 1'b0;
        logic       prev_busy  = 1'b0;
        logic [7:0] prev_data  = '0;
        logic [7:0] e;
        forever begin
          @(negedge clk);
          if (tx_valid === 1'b1) begin
            pulses++;
            chk("valid_single_cycle", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
              chk("unexpected_launch", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("launch_data", 32'(tx_data), 32'(e));
            end
          end
          if (prev_busy === 1'b1 && rst === 1'b0)
            chk("data_stable_busy", 32'(tx_data), 32'(prev_data));
          prev_valid = tx_valid;
          prev_busy  = tx_busy;
          prev_data  = tx_data;
        end
      end
      begin : tx_model
        forever begin
          @(negedge clk);
          if (tx_valid === 1'b1) begin
            @(posedge clk); #1 busy_model = 1'b1;
            repeat (11) @(posedge clk);
            #1 busy_model = 1'b0;
          end
        end
      end
    join_none

    // Reset state
    repeat (2) tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte, latency
    push_byte(8'hA5, 1'b1);
    chk("a5_count_after_push", 32'(count), 32'd1);
    chk("a5_empty_after_push", 32'(empty), 32'd0);
    tick();
    chk("a5_valid", 32'(tx_valid), 32'd1);
    chk("a5_data", 32'(tx_data), 32'hA5);
    chk("a5_empty_after_pop", 32'(empty), 32'd1);
    tick();
    chk("a5_valid_drop", 32'(tx_valid), 32'd0);
    wait_drain(50);

    // Three back-to-back pushes; second overlaps the first pop
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    chk("b2b_count", 32'(count), 32'd2);
    wait_drain(100);

    // Fill with TX held busy, then drop
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i), 1'b1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovf_before_drop", 32'(overflow), 32'd0);
    push_byte(8'h50, 1'b0);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_full", 32'(full), 32'd1);
    chk("drop_ovf", 32'(overflow), 32'(EXP_OVF));
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    wr_en = 1'b1; wr_data = 8'h5A; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("drop_wins_over_clr", 32'(overflow), 32'(EXP_OVF));
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr_again", 32'(overflow), 32'd0);
    chk("count_after_drops", 32'(count), 32'd16);

    // Release busy and push on the pop edge while full
    busy_force = 1'b0;
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("pop_edge_count", 32'(count), 32'd15);
    chk("pop_edge_full", 32'(full), 32'd0);
    chk("pop_edge_valid", 32'(tx_valid), 32'd1);
    chk("pop_edge_data", 32'(tx_data), 32'h40);
    chk("pop_edge_ovf", 32'(overflow), 32'(EXP_OVF));
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    wait_drain(400);

    // Spaced pushes while draining; pointers wrap
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(8'h80 + 3 * i), 1'b1);
      repeat (3) tick();
    end
    wait_drain(400);

    // Reset while the first of three frames is in WAIT_DONE
    push_byte(8'hC1, 1'b1);
    push_byte(8'hC2, 1'b0);
    push_byte(8'hC3, 1'b0);
    repeat (3) tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_full", 32'(full), 32'd0);
    chk("async_rst_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_data", 32'(tx_data), 32'd0);
    tick();
    rst = 1'b0;
    repeat (40) tick();
    chk("post_rst_empty", 32'(empty), 32'd1);

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    chk("total_launches", 32'(pulses), 32'd41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, frame payload width in bits.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 WR_EN  input  1  host push request, sampled on rising CLK.
REQ-006 WR_DATA  input  DATA_WIDTH  byte to enqueue when WR_EN is accepted.
REQ-007 FULL  output  1  high when COUNT equals DEPTH.
REQ-008 EMPTY  output  1  high when COUNT equals 0.
REQ-009 COUNT  output  log2(DEPTH)+1  number of stored entries.
REQ-010 TX_BUSY  input  1  busy indication from the downstream TX control FSM.
REQ-011 TX_DATA_VALID  output  1  single-cycle launch pulse to the TX control FSM.
REQ-012 TX_P_DATA  output  DATA_WIDTH  registered parallel byte presented to the serializer.
REQ-013 OVF_CLR  input  1  clears OVERFLOW (see Configuration).
REQ-014 OVERFLOW  output  1  sticky dropped-push flag (see Configuration).

Function
REQ-015 Storage: circular buffer of DEPTH entries, write and read pointers wrap from DEPTH-1 to 0.
REQ-016 Push accepted when WR_EN=1 and FULL=0 at the edge; WR_DATA stored at write pointer, pointer +1.
REQ-017 Push with FULL=1 is dropped and leaves storage, pointers and COUNT unchanged, including when a pop occurs in the same cycle.
REQ-018 Launch FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> LAUNCH when EMPTY=0 and TX_BUSY=0; on that edge head entry loaded into TX_P_DATA and read pointer +1 (pop).
REQ-020 LAUNCH: TX_DATA_VALID=1 for exactly this one cycle; unconditional -> WAIT_BUSY.
REQ-021 WAIT_BUSY -> WAIT_DONE when TX_BUSY=1; else remain.
REQ-022 WAIT_DONE -> IDLE when TX_BUSY=0; else remain.
REQ-023 TX_DATA_VALID=0 in all states other than LAUNCH.
REQ-024 TX_P_DATA held stable from the load edge until the next pop; never changes while TX_BUSY=1.
REQ-025 Latency: push accepted at edge N into an empty FIFO with FSM in IDLE -> pop at edge N+1, TX_DATA_VALID high between edges N+1 and N+2.
REQ-026 Simultaneous push and pop with 0<COUNT<DEPTH: both performed, COUNT unchanged.
REQ-027 Push into empty FIFO is not bypassed; data always passes through storage.
REQ-028 Back-to-back frames: minimum one IDLE cycle between WAIT_DONE exit and next LAUNCH.
REQ-029 COUNT, FULL, EMPTY are registered and reflect the state after the last edge.

Reset
REQ-030 RST=1 asynchronously forces: FSM to IDLE, pointers 0, COUNT 0, EMPTY 1, FULL 0, TX_DATA_VALID 0, TX_P_DATA 0, OVERFLOW 0.
REQ-031 RST asserted mid-frame discards all stored entries; no launch occurs until a new push after RST deasserts.
REQ-032 Storage array contents need not be reset.

Configuration
REQ-033 Macro UART_TX_FIFO_OVERFLOW_FLAG_EN selects overflow detection.
REQ-034 Defined: OVERFLOW set on the edge of any dropped push, held until OVF_CLR=1 at an edge; a drop on the same edge as OVF_CLR leaves OVERFLOW=1.
REQ-035 Undefined: OVERFLOW tied to 0, OVF_CLR ignored; ports remain present.

Verification
REQ-036 Reset then push 0xA5 with TX_BUSY=0 -> TX_DATA_VALID one-cycle pulse two edges after push, TX_P_DATA=0xA5, EMPTY returns to 1.
REQ-037 Push 0x11,0x22,0x33 back-to-back; model TX_BUSY high 1 cycle after each pulse for 11 cycles -> three pulses in order 0x11,0x22,0x33, each only after TX_BUSY has fallen.
REQ-038 Push 17 bytes with TX_BUSY=1 held -> FULL=1 after 16, 17th dropped, COUNT=16, OVERFLOW=1 (macro defined) or 0 (undefined); OVF_CLR pulse -> OVERFLOW=0.
REQ-039 FIFO full, TX_BUSY released, push on the pop edge -> push dropped, COUNT=15 after edge.
REQ-040 Three entries stored, RST pulsed during WAIT_DONE -> COUNT=0, EMPTY=1, TX_DATA_VALID=0, no further pulses without new pushes.
REQ-041 Push 20 bytes over time with draining so pointers wrap -> output sequence equals input sequence, no loss or duplication.
